// File: rtl/sum_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sum_acc_pkg
// Description : Shared types and width helper for the windowed sum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package sum_acc_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sum_acc_state_e;

    // Width that holds WINDOW samples of (data_width+1) bits without overflow.
    function automatic int acc_width(input int data_width, input int window);
        return data_width + 1 + $clog2(window);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_accumulator
// Description : Accumulates WINDOW adder samples; emits total and maximum through
//               a single-entry valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter  int DATA_WIDTH = 6,
    parameter  int WINDOW     = 4,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, WINDOW)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH:0]   sum_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic                  flush_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic [DATA_WIDTH:0]   max_o,
    output logic                  v_o,
    input  logic                  ready_i
);

    localparam int                  CNT_WIDTH = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW - 1);

    generate
        if (WINDOW < 2) begin : g_bad_window
            $error("sum_accumulator: WINDOW must be at least 2");
        end
    endgenerate

    sum_acc_state_e         state;
    sum_acc_state_e         state_next;
    logic [ACC_WIDTH-1:0]   run_acc;
    logic [DATA_WIDTH:0]    run_max;
    logic [CNT_WIDTH-1:0]   cnt;

    logic                   last;
    logic                   accept;
    logic                   complete;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [DATA_WIDTH:0]    max_sum;

    assign last     = (cnt == CNT_LAST);
    assign v_o      = (state == FULL);
    // Combinational from ready_i so a completing sample can enter in the same
    // cycle the previous result drains.
    assign ready_o  = ~rst_i & ~(v_o & ~ready_i & last);
    assign accept   = v_i & ready_o & ~flush_i;
    assign complete = accept & last;
    assign acc_sum  = run_acc + ACC_WIDTH'(sum_i);
    assign max_sum  = (sum_i > run_max) ? sum_i : run_max;

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (complete) state_next = FULL;
            FULL:    if (!complete && ready_i) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            run_acc <= '0;
            run_max <= '0;
            cnt     <= '0;
            acc_o   <= '0;
            max_o   <= '0;
        end else begin
            state <= state_next;
            if (flush_i || complete) begin
                run_acc <= '0;
                run_max <= '0;
                cnt     <= '0;
            end else if (accept) begin
                run_acc <= acc_sum;
                run_max <= max_sum;
                cnt     <= cnt + CNT_WIDTH'(1);
            end
            // Only a completing window may overwrite the held result.
            if (complete) begin
                acc_o <= acc_sum;
                max_o <= max_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_accumulator
// Description : Scoreboard bench for sum_accumulator at default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

    localparam int DW = 6;
    localparam int W  = 4;
    localparam int AW = 9;

    typedef struct packed {
        logic [AW-1:0] acc;
        logic [DW:0]   mx;
    } result_t;

    logic          clk_i   = 1'b0;
    logic          rst_i   = 1'b1;
    logic [DW:0]   sum_i   = '0;
    logic          v_i     = 1'b0;
    logic          ready_o;
    logic          flush_i = 1'b0;
    logic [AW-1:0] acc_o;
    logic [DW:0]   max_o;
    logic          v_o;
    logic          ready_i = 1'b1;

    int      errors = 0;
    int      checks = 0;
    result_t sb_q[$];

    sum_accumulator #(
        .DATA_WIDTH (DW),
        .WINDOW     (W)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sum_i   (sum_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .flush_i (flush_i),
        .acc_o   (acc_o),
        .max_o   (max_o),
        .v_o     (v_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Results leave on the handshake; compare each against the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && v_o && ready_i) begin
            result_t exp_r;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got acc=%0d max=%0d, required no output", acc_o, max_o);
            end else begin
                exp_r = sb_q.pop_front();
                if (acc_o !== exp_r.acc || max_o !== exp_r.mx) begin
                    errors++;
                    $display("FAIL sb_result: got acc=%0d max=%0d, required acc=%0d max=%0d",
                             acc_o, max_o, exp_r.acc, exp_r.mx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int a, input int m);
        result_t r;
        r.acc = AW'(a);
        r.mx  = (DW+1)'(m);
        sb_q.push_back(r);
    endtask

    task automatic send(input int s);
        v_i   = 1'b1;
        sum_i = (DW+1)'(s);
        tick();
        v_i   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0 || v_o !== 1'b0 || acc_o !== '0 || max_o !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b v=%b acc=%0d max=%0d, required 0 0 0 0",
                     ready_o, v_o, acc_o, max_o);
        end
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 1", ready_o);
        end
        tick();
    endtask

    task automatic test_basic();
        ready_i = 1'b1;
        push(100, 40);
        send(10); send(20); send(30); send(40);
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_v_rise: got %b, required 1", v_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_v_clear: got %b, required 0", v_o);
        end
        tick();
    endtask

    task automatic test_saturate();
        push(504, 126);
        for (int i = 0; i < W; i++) send(126);
        push(0, 0);
        for (int i = 0; i < W; i++) send(0);
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_zero_window_v: got %b, required 1", v_o);
        end
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        push(100, 40);
        send(10); send(20); send(30); send(40);
        for (int s = 1; s <= 3; s++) begin
            v_i   = 1'b1;
            sum_i = (DW+1)'(s);
            @(negedge clk_i);
            checks++;
            if (ready_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_accept_%0d: got ready=%b, required 1", s, ready_o);
            end
            tick();
        end
        v_i   = 1'b1;
        sum_i = 7'd4;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checks++;
            if (ready_o !== 1'b0 || v_o !== 1'b1 || acc_o !== 9'd100 || max_o !== 7'd40) begin
                errors++;
                $display("FAIL bp_hold: got ready=%b v=%b acc=%0d max=%0d, required 0 1 100 40",
                         ready_o, v_o, acc_o, max_o);
            end
            tick();
        end
        ready_i = 1'b1;
        push(10, 4);
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, required 1", ready_o);
        end
        tick();
        v_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b1 || acc_o !== 9'd10) begin
            errors++;
            $display("FAIL bp_new_result: got v=%b acc=%0d, required 1 10", v_o, acc_o);
        end
        tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b1;
        send(5); send(7);
        tick(); tick();
        flush_i = 1'b1;
        send(9);
        flush_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checks++;
            if (v_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_output: got v=%b, required 0", v_o);
            end
            tick();
        end
        push(4, 1);
        for (int i = 0; i < W; i++) send(1);
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_next_window_v: got %b, required 1", v_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        for (int i = 0; i < W; i++) send(2);
        send(8); send(8);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b0 || acc_o !== '0 || max_o !== '0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got v=%b acc=%0d max=%0d ready=%b, required 0 0 0 1",
                     v_o, acc_o, max_o, ready_o);
        end
        ready_i = 1'b1;
        push(12, 3);
        for (int i = 0; i < W; i++) send(3);
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b1 || acc_o !== 9'd12) begin
            errors++;
            $display("FAIL reset_mid_next: got v=%b acc=%0d, required 1 12", v_o, acc_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        push(4, 1);
        for (int i = 0; i < W; i++) send(1);
        push(40, 10);
        send(10); send(10); send(10);
        ready_i = 1'b1;
        v_i     = 1'b1;
        sum_i   = 7'd10;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got ready=%b v=%b, required 1 1", ready_o, v_o);
        end
        tick();
        v_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b1 || acc_o !== 9'd40 || max_o !== 7'd10) begin
            errors++;
            $display("FAIL b2b_replace: got v=%b acc=%0d max=%0d, required 1 40 10",
                     v_o, acc_o, max_o);
        end
        tick();
        @(negedge clk_i);
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got v=%b, required 0", v_o);
        end
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sum_accumulator.md
# sum_accumulator

Windowed accumulator that sits directly downstream of the registered adder stage. It consumes the adder's `DATA_WIDTH+1`-bit sum stream and accumulates `WINDOW` valid samples into a running total. For each window it emits the total and the window maximum through a single-entry, valid/ready-handshaked output register. Back-pressure reaches the producer only when a new window completes while the previous result is still unconsumed.

## Interface
Parameters:
- `DATA_WIDTH`, default 6: operand width of the upstream adder. Sample width is `DATA_WIDTH+1`.
- `WINDOW`, default 4: samples per result. Legal range is ≥2; an elaboration-time assertion enforces it.
- `ACC_WIDTH`, derived and not overridable: `DATA_WIDTH+1+$clog2(WINDOW)`.

Ports:
- `clk_i`  in  1  the single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `sum_i`  in  `DATA_WIDTH+1`  sample from the adder.
- `v_i`  in  1  `sum_i` is valid this cycle.
- `ready_o`  out  1  block accepts `sum_i` this cycle.
- `flush_i`  in  1  discard the partial window in progress.
- `acc_o`  out  `ACC_WIDTH`  window total, unsigned.
- `max_o`  out  `DATA_WIDTH+1`  largest sample in the window.
- `v_o`  out  1  `acc_o`/`max_o` are valid.
- `ready_i`  in  1  downstream consumes the result this cycle.

## Operation
- **Accept:** a sample is accepted when `v_i & ready_o & ~flush_i`.
- **Running state:**
  - `run_acc` (`ACC_WIDTH` bits), `run_max`, and `cnt` (0..`WINDOW-1`) make up the running state.
  - A non-final accept does `run_acc += sum_i`, `run_max = max(run_max, sum_i)`, `cnt++`.
- **Window completion:** an accept with `cnt == WINDOW-1` completes the window.
  - Output register loads `acc_o = run_acc + sum_i` and `max_o = max(run_max, sum_i)`.
  - `v_o` is set.
  - `run_acc`, `run_max` and `cnt` clear to 0 in the same cycle.
- **States (output side):**
  - `EMPTY` (`v_o=0`): goes to `FULL` on window completion.
  - `FULL` (`v_o=1`): goes to `EMPTY` on `ready_i`, unless a window completes in that same cycle, in which case it stays `FULL` with the new result.
- **`ready_o`:** equals `~rst_i & ~(v_o & ~ready_i & cnt == WINDOW-1)`.
  - This is a combinational path from `ready_i` to `ready_o`.
  - It allows a completing sample to be accepted in the same cycle the old result is consumed.
- **Flush:**
  - `flush_i` clears `run_acc`, `run_max` and `cnt`.
  - Any concurrent `v_i` sample is dropped; flush wins.
  - A pending output (`v_o`, `acc_o`, `max_o`) is unaffected.
- **Arithmetic:** unsigned and exact. `ACC_WIDTH` guarantees no overflow, e.g. 4×126 = 504 fits in 9 bits for the defaults.
- **`v_i` gaps:** idle cycles with `v_i` low do not advance `cnt`. A window is `WINDOW` accepted samples, not consecutive cycles.
- **Output stability:** `acc_o`/`max_o` are held stable while `v_o & ~ready_i`.

## Timing
- **Latency:** `v_o` rises in the cycle after the final sample of a window is accepted.
- **Throughput:** one sample per cycle when `ready_i` is held high. No bubble at window boundaries.
- **Reset (synchronous, `rst_i` high at a rising edge):**
  - Outputs: `v_o=0`, `acc_o=0`, `max_o=0`.
  - Internal state: `run_acc=0`, `run_max=0`, `cnt=0`.
  - `ready_o=0` while `rst_i` is high and 1 in the first cycle after.
- **Reset mid-window or with a pending output:** everything is discarded and there is no partial result.
- **Ready/valid protocol:**
  - Once raised, `v_o` stays high until the handshake `v_o & ready_i`.
  - `ready_i` may toggle freely.
  - `v_i` may be asserted without waiting for `ready_o`; an unaccepted sample is the producer's responsibility to hold.

## Structure
- Package `sum_acc_pkg` holds:
  - the output-state enum `sum_acc_state_e {EMPTY, FULL}`;
  - the width helper function `acc_width(data_width, window)`.
- No sub-module. The counter, running registers and single-entry output register live in one always_ff block plus combinational next-state logic.

## Test plan
- **Basic window** (`WINDOW=4`, `ready_i=1`): `sum_i` 10, 20, 30, 40 on consecutive cycles → next cycle `v_o=1`, `acc_o=100`, `max_o=40`. `v_o` clears one cycle later.
- **Saturating values:** 126 ×4 → `acc_o=504`, `max_o=126`, no wrap. Then 0 ×4 → `acc_o=0`, `max_o=0`.
- **Back-pressure:**
  - Stimulus: hold `ready_i=0` after result 100; stream 1, 2, 3, 4.
  - Required: 1, 2, 3 accepted; `ready_o=0` while 4 is offered; `acc_o` stays 100.
  - Then raise `ready_i`: 4 accepted in that cycle, next cycle `acc_o=10`, `max_o=4`.
- **Gaps and flush:**
  - Samples 5 and 7, two `v_i`-low cycles, then `flush_i` together with `v_i`/`sum_i=9` → no output.
  - Following 1, 1, 1, 1 → `acc_o=4`, `max_o=1`.
- **Reset mid-operation:**
  - Stimulus: result pending (`v_o=1`, `ready_i=0`) and 2 samples into the next window, then `rst_i` for one cycle.
  - Required: `v_o`, `acc_o` and `max_o` go to 0.
  - Next 4 samples of 3 → `acc_o=12`.
- **Simultaneous consume and complete:** `v_o=1`, `ready_i=1` in the same cycle the 4th sample arrives → the new result replaces the old one with no bubble and `v_o` stays high.
